fifo_word_packer: RTL and testbench

Read-side consumer for the mixed-clock FIFO: pulls `BIT_WIDTH`-bit entries from the FIFO read port and packs `LANES` consecutive entries into one wide word, presented on a valid/ready output. It runs entirely in the FIFO's read clock domain and issues `dequeue` itself. It accounts for the FIFO's one-cycle read latency, so it never over-reads. A tail-flush request emits a trailing partial word.

---
 rtl/fifo_word_packer.sv | 127 ++++++++++++
 tb/tb_fifo_word_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Read-side consumer of the mixed-clock FIFO. It dequeues BIT_WIDTH-bit entries,
// allowing for the FIFO's one-cycle read latency. It packs LANES consecutive
// entries into one word and presents that word on a valid/ready output.
// A tail flush emits the trailing partial word. Unused lanes of that word are zero.
module fifo_word_packer #(
   parameter int BIT_WIDTH = 8,
   parameter int LANES     = 4
) (
   input  logic                         read_clock,
   input  logic                         reset_n,
   input  logic [BIT_WIDTH-1:0]         fifo_data,
   input  logic                         fifo_empty,
   output logic                         fifo_dequeue,
   input  logic                         tail_flush,
   output logic [BIT_WIDTH*LANES-1:0]   word_out,
   output logic [$clog2(LANES+1)-1:0]   word_count,
   output logic                         word_valid,
   input  logic                         word_ready,
   output logic                         tail_done
);

   localparam int CW = $clog2(LANES + 1);
   localparam logic [CW-1:0] LANES_C = CW'(LANES);
   localparam logic [CW:0]   LANES_P = (CW + 1)'(LANES);

   typedef enum logic {FILL, DRAIN} state_t;
   typedef logic [LANES-1:0][BIT_WIDTH-1:0] word_t;

   state_t        state_q, state_d;
   word_t         buf_q, buf_d, tail_word;
   logic [CW-1:0] lane_cnt_q, lane_cnt_d, cnt_after;
   logic [CW:0]   pending;
   logic          inflight_q;
   logic          out_free, full_load, tail_load, tail_done_d;

   // The output register can take a new word if it is empty, or if its current word is accepted on this edge.
   assign out_free = ~word_valid | word_ready;
   assign pending  = {1'b0, lane_cnt_q} + (CW + 1)'(inflight_q);

   // Dequeue only when the entry can be placed on arrival: either a lane is free
   // counting in-flight data, or the arriving entry completes a word that can
   // move straight into a free output register.
   assign fifo_dequeue = reset_n & ~fifo_empty & (state_q == FILL) & ~tail_flush &
                         ((pending < LANES_P) | (inflight_q & out_free));

   // Capture the in-flight entry into the next free lane and build the zero-padded tail word.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      buf_d     = buf_q;
      tail_word = '0;
      for (int k = 0; k < LANES; k++) begin
         if (inflight_q && lane_cnt_q == CW'(k)) buf_d[k] = fifo_data;
         if (CW'(k) < lane_cnt_q)                tail_word[k] = buf_q[k];
      end
      cnt_after = lane_cnt_q + CW'(inflight_q);
   end

   // Next-state logic for the FSM and the word-completion and flush-completion decisions.
   always_comb begin
      state_d     = state_q;
      tail_load   = 1'b0;
      tail_done_d = 1'b0;
      full_load   = (cnt_after == LANES_C) && out_free;
      lane_cnt_d  = full_load ? '0 : cnt_after;
      case (state_q)
         FILL: begin
            if (tail_flush) state_d = DRAIN;
         end
         DRAIN: begin
            if (!inflight_q) begin
               if (lane_cnt_q == '0) begin
                  tail_done_d = 1'b1;
                  state_d     = FILL;
               end else if (lane_cnt_q != LANES_C && out_free) begin
                  tail_load   = 1'b1;
                  tail_done_d = 1'b1;
                  lane_cnt_d  = '0;
                  state_d     = FILL;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State register.
   always_ff @(posedge read_clock) begin
      if (!reset_n) state_q <= FILL;
      else          state_q <= state_d;
   end

   // Assembly buffer storage.
   always_ff @(posedge read_clock) begin
      // NOTE: the lane storage is not reset. Only lanes below lane_cnt are ever emitted, so stale contents are never visible.
      buf_q <= buf_d;
   end

   // Lane counter, in-flight tracking and output register.
   always_ff @(posedge read_clock) begin
      // NOTE: state is updated with non-blocking assignments, so every block samples values from before the edge.
      if (!reset_n) begin
         lane_cnt_q <= '0;
         inflight_q <= 1'b0;
         word_out   <= '0;
         word_count <= '0;
         word_valid <= 1'b0;
         tail_done  <= 1'b0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
         inflight_q <= fifo_dequeue;
         tail_done  <= tail_done_d;
         if (full_load) begin
            word_out   <= buf_d;
            word_count <= LANES_C;
            word_valid <= 1'b1;
         end else if (tail_load) begin
            word_out   <= tail_word;
            word_count <= lane_cnt_q;
            word_valid <= 1'b1;
         end else if (word_ready) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
// Directed bench for fifo_word_packer with BIT_WIDTH=8 and LANES=4.
// A FIFO model feeds the DUT. A stream-level scoreboard groups the dequeued
// entries into the expected words. Per-test literal values pin the scoreboard itself.
module tb_fifo_word_packer;

   localparam int BW = 8;
   localparam int LN = 4;

   logic              read_clock = 1'b0;
   logic              reset_n    = 1'b0;
   logic [BW-1:0]     fifo_data  = '0;
   logic              fifo_empty = 1'b1;
   logic              fifo_dequeue;
   logic              tail_flush = 1'b0;
   logic [BW*LN-1:0]  word_out;
   logic [2:0]        word_count;
   logic              word_valid;
   logic              word_ready = 1'b0;
   logic              tail_done;

   fifo_word_packer #(.BIT_WIDTH(BW), .LANES(LN)) dut (
      .read_clock   (read_clock),
      .reset_n      (reset_n),
      .fifo_data    (fifo_data),
      .fifo_empty   (fifo_empty),
      .fifo_dequeue (fifo_dequeue),
      .tail_flush   (tail_flush),
      .word_out     (word_out),
      .word_count   (word_count),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .tail_done    (tail_done)
   );

   always #5 read_clock = ~read_clock;

   int total = 0;
   int bad   = 0;

   // FIFO contents, scoreboard state and observation logs.
   logic [BW-1:0] fifo_q[$];
   logic [BW-1:0] partial[$];
   logic [63:0]   exp_q[$];
   logic [63:0]   acc_q[$];
   int            tails_owed = 0;
   int            n_deq = 0, n_tail = 0, n_valid = 0;
   int            deq_run = 0, deq_run_max = 0;
   int            cyc = 0, first_deq_cyc = -1, first_valid_cyc = -1;
   logic          stall_prev = 1'b0;
   logic [63:0]   stall_val  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack(input int cnt, input logic [31:0] w);
      return (64'(cnt) << 32) | 64'(w);
   endfunction

   function automatic logic [63:0] pack_partial();
      logic [31:0] w = '0;
      for (int i = 0; i < partial.size(); i++) w = w | (32'(partial[i]) << (8 * i));
      return pack(partial.size(), w);
   endfunction

   task automatic fifo_push(input logic [BW-1:0] v);
      fifo_q.push_back(v);
      fifo_empty = 1'b0;
   endtask

   // FIFO read port: data_out updates in the cycle after a taken dequeue.
   initial begin
      logic take;
      forever begin
         @(negedge read_clock);
         take = fifo_dequeue && !fifo_empty;
         @(posedge read_clock);
         #1;
         if (take) begin
            fifo_data  = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
         end
      end
   end

   // Compare process. It runs at mid-cycle, while the inputs for the coming edge are stable.
   always @(negedge read_clock) begin
      cyc++;
      if (!reset_n) begin
         partial.delete();
         exp_q.delete();
         tails_owed = 0;
         stall_prev = 1'b0;
         deq_run    = 0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 64'(word_valid), 64'd1);
            check("hold_word", pack(int'(word_count), word_out), stall_val);
         end
         if (fifo_empty)  check("deq_while_empty", 64'(fifo_dequeue), 64'd0);
         if (tail_flush)  check("flush_blocks_deq", 64'(fifo_dequeue), 64'd0);
         if (fifo_dequeue && !fifo_empty) begin
            partial.push_back(fifo_q[0]);
            n_deq++;
            deq_run++;
            if (deq_run > deq_run_max) deq_run_max = deq_run;
            if (first_deq_cyc < 0) first_deq_cyc = cyc;
            if (partial.size() == LN) begin
               exp_q.push_back(pack_partial());
               partial.delete();
            end
         end else begin
            deq_run = 0;
         end
         if (tail_flush) begin
            if (partial.size() > 0) exp_q.push_back(pack_partial());
            partial.delete();
            tails_owed++;
         end
         if (word_valid) begin
            n_valid++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (word_valid && word_ready) begin
            acc_q.push_back(pack(int'(word_count), word_out));
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %0h expected none", pack(int'(word_count), word_out));
            end else begin
               check("word", pack(int'(word_count), word_out), exp_q.pop_front());
            end
         end
         if (tail_done) begin
            n_tail++;
            if (tails_owed == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_tail_done: got 1 expected 0");
            end else begin
               tails_owed--;
            end
         end
         stall_prev = word_valid && !word_ready;
         stall_val  = pack(int'(word_count), word_out);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge read_clock);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      reset_n    = 1'b0;
      tail_flush = 1'b0;
      word_ready = 1'b0;
      tick(n);
      fifo_q.delete();
      fifo_empty = 1'b1;
      acc_q.delete();
      n_deq = 0; n_tail = 0; n_valid = 0; deq_run_max = 0;
      first_deq_cyc = -1; first_valid_cyc = -1;
   endtask

   task automatic pulse_flush();
      tail_flush = 1'b1;
      tick(1);
      tail_flush = 1'b0;
   endtask

   task automatic end_checks(input string name);
      check({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
      check({name, "_tails_owed"}, 64'(tails_owed), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Test 1: eight preloaded entries with the output always ready.
      do_reset(2);
      for (int i = 1; i <= 8; i++) fifo_push(BW'(i));
      #1;
      check("rst_valid", 64'(word_valid), 64'd0);
      check("rst_word", 64'(word_out), 64'd0);
      check("rst_count", 64'(word_count), 64'd0);
      check("rst_tail_done", 64'(tail_done), 64'd0);
      check("rst_deq", 64'(fifo_dequeue), 64'd0);
      word_ready = 1'b1;
      reset_n    = 1'b1;
      for (int i = 0; i < 40 && acc_q.size() < 2; i++) tick(1);
      check("t1_words", 64'(acc_q.size()), 64'd2);
      if (acc_q.size() >= 2) begin
         check("t1_word0", acc_q[0], pack(4, 32'h04030201));
         check("t1_word1", acc_q[1], pack(4, 32'h08070605));
      end
      check("t1_deq_total", 64'(n_deq), 64'd8);
      check("t1_deq_run", 64'(deq_run_max), 64'd8);
      check("t1_latency", 64'(first_valid_cyc - first_deq_cyc), 64'd5);
      end_checks("t1");

      // Test 2: output stalled for six cycles after the first word.
      do_reset(2);
      for (int i = 1; i <= 12; i++) fifo_push(BW'(i));
      reset_n = 1'b1;
      for (int i = 0; i < 20 && !word_valid; i++) tick(1);
      check("t2_first_valid", 64'(word_valid), 64'd1);
      tick(6);
      check("t2_stall_word", 64'(word_out), 64'h04030201);
      check("t2_stall_deq_total", 64'(n_deq), 64'd8);
      check("t2_stall_deq", 64'(fifo_dequeue), 64'd0);
      word_ready = 1'b1;
      tick(1);
      check("t2_next_valid", 64'(word_valid), 64'd1);
      check("t2_next_word", pack(int'(word_count), word_out), pack(4, 32'h08070605));
      for (int i = 0; i < 30 && acc_q.size() < 3; i++) tick(1);
      check("t2_words", 64'(acc_q.size()), 64'd3);
      if (acc_q.size() >= 3) check("t2_word2", acc_q[2], pack(4, 32'h0C0B0A09));
      check("t2_deq_total", 64'(n_deq), 64'd12);
      end_checks("t2");

      // Test 3: three entries followed by a tail flush.
      do_reset(2);
      fifo_push(8'hAA); fifo_push(8'hBB); fifo_push(8'hCC);
      word_ready = 1'b1;
      reset_n    = 1'b1;
      tick(6);
      pulse_flush();
      for (int i = 0; i < 10 && n_tail < 1; i++) tick(1);
      tick(3);
      check("t3_tail_pulses", 64'(n_tail), 64'd1);
      check("t3_words", 64'(acc_q.size()), 64'd1);
      if (acc_q.size() >= 1) check("t3_tail_word", acc_q[0], pack(3, 32'h00CCBBAA));
      end_checks("t3");

      // Test 4: flush raised in a cycle that would dequeue, with one entry in flight.
      do_reset(2);
      fifo_push(8'h11); fifo_push(8'h22);
      word_ready = 1'b1;
      reset_n    = 1'b1;
      tick(1);
      tail_flush = 1'b1;
      #1;
      check("t4_flush_blocks_deq", 64'(fifo_dequeue), 64'd0);
      tick(1);
      tail_flush = 1'b0;
      for (int i = 0; i < 10 && n_tail < 1; i++) tick(1);
      tick(5);
      check("t4_first_tail", 64'(acc_q.size()), 64'd1);
      if (acc_q.size() >= 1) check("t4_tail_word", acc_q[0], pack(1, 32'h00000011));
      pulse_flush();
      for (int i = 0; i < 10 && n_tail < 2; i++) tick(1);
      tick(2);
      check("t4_tail_pulses", 64'(n_tail), 64'd2);
      if (acc_q.size() >= 2) check("t4_second_tail", acc_q[1], pack(1, 32'h00000022));
      check("t4_deq_total", 64'(n_deq), 64'd2);
      end_checks("t4");

      // Test 5: flush with an empty assembly buffer.
      do_reset(2);
      word_ready = 1'b1;
      reset_n    = 1'b1;
      tick(2);
      pulse_flush();
      for (int i = 0; i < 10 && n_tail < 1; i++) tick(1);
      tick(3);
      check("t5_tail_pulses", 64'(n_tail), 64'd1);
      check("t5_no_valid", 64'(n_valid), 64'd0);
      end_checks("t5");

      // Test 6: reset with two entries captured and one in flight.
      do_reset(2);
      fifo_push(8'h51); fifo_push(8'h52); fifo_push(8'h53);
      word_ready = 1'b1;
      reset_n    = 1'b1;
      tick(3);
      reset_n = 1'b0;
      for (int i = 1; i <= 4; i++) fifo_push(8'h60 + BW'(i));
      #1;
      check("t6_deq_in_reset", 64'(fifo_dequeue), 64'd0);
      tick(1);
      check("t6_rst_outputs", {word_out, 29'd0, word_count, word_valid, tail_done}, 64'd0);
      acc_q.delete();
      reset_n = 1'b1;
      for (int i = 0; i < 20 && acc_q.size() < 1; i++) tick(1);
      tick(2);
      check("t6_words", 64'(acc_q.size()), 64'd1);
      if (acc_q.size() >= 1) check("t6_word", acc_q[0], pack(4, 32'h64636261));
      end_checks("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
